// File: rtl/unroll_issue_collector_if.sv
// rtl/unroll_issue_collector_if.sv - issue bundle handshake between the collector and the CGRA issue stage
interface unroll_issue_collector_if #(
  parameter int NUM_LANES = 4,
  parameter int TID_W     = 8
);
  logic                       issue_valid;
  logic                       issue_ready;
  logic [NUM_LANES*TID_W-1:0] issue_tid;
  logic [NUM_LANES-1:0]       issue_mask;

  modport master (output issue_valid, output issue_tid, output issue_mask, input issue_ready);
  modport slave  (input issue_valid, input issue_tid, input issue_mask, output issue_ready);
endinterface

// File: rtl/unroll_issue_collector.sv
// rtl/unroll_issue_collector.sv - lock-step issue bundle collector for unrolled lanes; optional stall counter under UNROLL_ISSUE_PERF_EN
module unroll_issue_collector #(
  parameter int NUM_LANES = 4,
  parameter int TID_W     = 8,
  parameter int CNT_W     = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 unrolling_factor,
  input  logic [NUM_LANES*TID_W-1:0] lane_tid,
  input  logic [NUM_LANES-1:0]       lane_valid,
  input  logic [NUM_LANES-1:0]       lane_done,
  output logic [NUM_LANES-1:0]       lane_update,
  output logic                       lane_restart,
  unroll_issue_collector_if.master   issue,
  output logic                       busy,
  output logic                       dispatch_done,
  output logic [CNT_W-1:0]           issued_count,
  output logic [15:0]                stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_SETTLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W:0] CNT_SAT = (CNT_W+1)'(256);

  state_t                     state, state_nxt;
  logic [NUM_LANES-1:0]       en_q, en_dec, take;
  logic                       out_valid;
  logic [NUM_LANES*TID_W-1:0] out_tid, cap_tid;
  logic [NUM_LANES-1:0]       out_mask;
  logic                       lane_restart_q;
  logic [CNT_W-1:0]           count_q;
  logic [CNT_W:0]             pop, sum;
  logic                       bundle_ready, capture, finish, start_go;

  // Enabled-lane decode from the raw factor; only latched on the start transition
  always_comb begin
    int lanes;
    case (unrolling_factor)
      2'd0:    lanes = 1;
      2'd1:    lanes = 2;
      default: lanes = 4;
    endcase
    en_dec = '0;
    for (int i = 0; i < NUM_LANES; i++) en_dec[i] = (i < lanes);
  end

  assign start_go     = (state == S_IDLE) && start;
  assign take         = en_q & lane_valid;
  // A lane still computing (neither valid nor done) holds back the whole bundle
  assign bundle_ready = (&(~en_q | lane_valid | lane_done)) && (|take);
  assign capture      = (state == S_DISPATCH) && bundle_ready && (!out_valid || issue.issue_ready);
  assign finish       = (&(~en_q | lane_done)) && !(|take);
  assign lane_update  = capture ? take : '0;

  // Bundle payload and thread count for the current capture
  always_comb begin
    cap_tid = '0;
    pop     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (take[i]) cap_tid[i*TID_W +: TID_W] = lane_tid[i*TID_W +: TID_W];
      pop = pop + {{CNT_W{1'b0}}, take[i]};
    end
    sum = {1'b0, count_q} + pop;
    if (sum > CNT_SAT) sum = CNT_SAT;
  end

  // Next-state decode for the block sequencing FSM
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = S_RESTART;
      S_RESTART:  state_nxt = S_SETTLE;
      S_SETTLE:   state_nxt = S_DISPATCH;
      S_DISPATCH: if (finish) state_nxt = S_DRAIN;
      S_DRAIN:    if (!out_valid) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Per-block control: latched lane enables, restart strobe, issued-thread counter
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q           <= '0;
      lane_restart_q <= 1'b0;
      count_q        <= '0;
    end else begin
      lane_restart_q <= start_go;
      if (start_go) begin
        en_q    <= en_dec;
        count_q <= '0;
      end else if (capture) begin
        count_q <= sum[CNT_W-1:0];
      end
    end
  end

  // Output register: load on capture (replacing an accepted bundle without a bubble), clear on bare accept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tid   <= '0;
      out_mask  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_tid   <= cap_tid;
      out_mask  <= take;
    end else if (out_valid && issue.issue_ready) begin
      out_valid <= 1'b0;
      out_tid   <= '0;
      out_mask  <= '0;
    end
  end

  assign issue.issue_valid = out_valid;
  assign issue.issue_tid   = out_tid;
  assign issue.issue_mask  = out_mask;
  assign lane_restart      = lane_restart_q;
  assign busy              = (state != S_IDLE);
  assign dispatch_done     = (state == S_DONE);
  assign issued_count      = count_q;

`ifdef UNROLL_ISSUE_PERF_EN
  logic [15:0] stall_q;
  logic        stall_hit;

  assign stall_hit = (out_valid && !issue.issue_ready) ||
                     ((state == S_DISPATCH) && (|(en_q & ~lane_valid & ~lane_done)));

  // Stall counter: back-pressure or lane-wait cycles, saturating, cleared on start
  always_ff @(posedge clk) begin
    if (rst)                                  stall_q <= '0;
    else if (start_go)                        stall_q <= '0;
    else if (stall_hit && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/unroll_issue_collector.md
Name: unroll_issue_collector

Overview:
- Sits directly downstream of the per-lane next-active-thread units in the CGRA dispatcher.
- Gathers one thread index from each enabled unrolling lane (1, 2 or 4 lanes) into a lock-step issue bundle and presents it to the CGRA issue stage over a valid/ready handshake.
- Pops the lane FIFOs through per-lane update pulses, drives lane restart at the start of a block, and reports block completion.

Parameters:
- NUM_LANES, 4, number of unrolling lanes; fixed at 4 for unrolling factor encodings 0/1/2.
- TID_W, 8, width of one lane thread index (active_mask_index).
- CNT_W, 9, width of issued-thread counter; holds the maximum of 256.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin dispatch of a new block; sampled only in IDLE
- unrolling_factor  in  2  0=1 lane, 1=2 lanes, 2=4 lanes, 3=treated as 2
- lane_tid  in  NUM_LANES*TID_W  per-lane head index; lane i occupies bits [i*TID_W +: TID_W]
- lane_valid  in  NUM_LANES  per-lane head valid
- lane_done  in  NUM_LANES  per-lane completion (all indices produced and FIFO empty)
- lane_update  out  NUM_LANES  per-lane pop strobe, combinational
- lane_restart  out  1  restart strobe to all lanes, registered
- issue_valid  out  1  bundle valid
- issue_ready  in  1  downstream accept
- issue_tid  out  NUM_LANES*TID_W  bundle indices; slots outside issue_mask are 0
- issue_mask  out  NUM_LANES  per-slot valid
- busy  out  1  high in any state other than IDLE
- dispatch_done  out  1  one-cycle pulse at block completion
- issued_count  out  CNT_W  threads issued since the last start
- stall_cycles  out  16  performance counter; see Optional Feature

Behaviour:
- Reset values: state=IDLE; all outputs 0; output register empty.
- Reset mid-operation overrides everything and returns to IDLE. No dispatch_done pulse is produced.
- Enabled lanes: en[i] = (i < 1 << min(unrolling_factor, 2)). Lanes outside en are ignored and never receive lane_update.
- Decode unrolling_factor only at the start transition (latched). Changes after that have no effect until the next block.
- States:
  - IDLE: start=1 -> RESTART; issued_count cleared.
  - RESTART: lane_restart=1 for exactly 1 cycle -> SETTLE.
  - SETTLE: 1 cycle; lane outputs update after the restart -> DISPATCH.
  - DISPATCH: forms bundles (rules below); on the finish condition -> DRAIN.
  - DRAIN: wait until the output register is empty -> DONE.
  - DONE: dispatch_done=1 for 1 cycle -> IDLE.
- start while not IDLE is ignored.
- Bundle ready condition: for every enabled lane, lane_valid | lane_done, and at least one enabled lane has lane_valid.
  - This keeps lanes in lock-step: a lane still computing stalls the whole bundle.
- Capture condition: bundle ready AND (output register empty OR (issue_valid & issue_ready)).
  - On capture: issue_tid/issue_mask load from the valid enabled lanes; issue_valid=1 the next cycle.
  - lane_update[i] = en[i] & lane_valid[i] in the same cycle as capture.
  - issued_count += popcount(mask), saturating at 256.
- Latency: from lane_valid to issue_valid is 1 cycle. Back-to-back bundles sustain 1 per cycle while issue_ready=1.
- Output holding: issue_valid stays high and issue_tid/issue_mask stay stable until issue_ready. The register clears on accept when no new capture occurs.
- Finish condition: all enabled lanes have lane_done=1 and none have lane_valid.
  - Zero-thread block (all lanes done right after SETTLE): DISPATCH -> DRAIN -> DONE with no bundle issued and issued_count=0.
- Simultaneous accept and capture in the same cycle: the register is replaced with no bubble.
- lane_update is never asserted outside DISPATCH.

Optional Feature:
- Macro: UNROLL_ISSUE_PERF_EN.
- Defined: stall_cycles counts cycles with issue_valid & !issue_ready, plus DISPATCH cycles where some enabled lane is neither valid nor done.
  - Saturates at 16'hFFFF and clears on start.
- Undefined: stall_cycles tied to 0 and no counter logic is synthesized.
- Functional behaviour of all other ports is identical in both builds.

Test Plan:
- Factor 0, lane0 supplies tids 3,7,9 then done, issue_ready=1 -> three bundles with mask 0001 and tids 3,7,9 on consecutive cycles; issued_count=3; one dispatch_done pulse.
- Factor 2, lanes supply (0,1,2,3) then (4,5,6) and lane3 done -> bundles mask 1111 then 0111 with lane3 slot 0; issued_count=7.
- Factor 1, lane1 valid 2 cycles after lane0 -> no capture and no lane_update until both are valid; bundle issued 1 cycle after lane1 valid; lanes 2/3 never updated.
- issue_ready held 0 for 5 cycles with a bundle pending -> issue_tid/issue_mask stable, lane_update=0; stall_cycles=5 with UNROLL_ISSUE_PERF_EN defined, 0 without.
- All enabled lanes done right after SETTLE -> no issue_valid; dispatch_done 3 cycles after SETTLE (DISPATCH, DRAIN, DONE); issued_count=0.
- rst asserted in DISPATCH with a bundle held -> next cycle: state IDLE, issue_valid=0, busy=0, no dispatch_done; a following start produces lane_restart pulse 1 cycle later.
